traffic_request_conditioner: RTL

Upstream front end for traffic_fsm. Conditions the raw loop-sensor inputs for the north-south and east-west approaches: synchronise, debounce, and latch the request until it is served. Drives cars_ns and cars_ew into traffic_fsm. Takes green_N and green_E back from traffic_fsm so that a request is held until its own green has been given. The two directions are independent, identical channels.

---
 rtl/traffic_request_conditioner.sv | 309 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/traffic_request_conditioner.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// traffic_request_conditioner
//
// Front end for traffic_fsm. Each approach (north-south, east-west) has its
// own independent channel. A channel synchronises its raw loop sensor,
// debounces it, and latches a request until that approach has had its own
// green. The two channels never interact.
//
// Optional build macro: STUCK_DETECT_EN
//   When defined, each channel watches for a sensor that reports presence
//   for STUCK_CYCLES consecutive cycles. It then raises a sticky fault flag
//   and forces its request high, so traffic_fsm falls back to fixed-time
//   service for that approach. When the macro is not defined, the fault
//   outputs are tied low and no stuck counter exists.
//
// Ports (top):
//   clk            in   system clock, rising edge
//   rst            in   asynchronous, active-high reset
//   sensor_ns_raw  in   raw NS loop detector (asynchronous to clk)
//   sensor_ew_raw  in   raw EW loop detector (asynchronous to clk)
//   green_N        in   NS green from traffic_fsm
//   green_E        in   EW green from traffic_fsm
//   cars_ns        out  registered NS request to traffic_fsm
//   cars_ew        out  registered EW request to traffic_fsm
//   det_ns         out  debounced NS presence
//   det_ew         out  debounced EW presence
//   fault_ns       out  sticky NS stuck-sensor flag
//   fault_ew       out  sticky EW stuck-sensor flag
//   state_ns       out  NS request FSM state (debug: 0 IDLE, 1 PENDING,
//                       2 SERVING)
//   state_ew       out  EW request FSM state (debug, same encoding)
//
// Handshake: there is no valid/ready pair here. cars_x is a level. It rises
// when a debounced vehicle is seen. It stays high until that approach has
// been given green and the vehicle has left, plus a hold stretch.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// traffic_request_channel
//
// One approach: synchroniser -> debouncer -> request FSM (-> stuck
// detector).
//
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   sensor_raw   raw loop detector input
//   own_green    this approach's green from traffic_fsm
//   cars         request to traffic_fsm (registered)
//   det          debounced presence (registered)
//   fault        sticky stuck-sensor flag (0 when the feature is not built)
//   state        request FSM state, for debug
// ---------------------------------------------------------------------------
module traffic_request_channel #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 16,
    parameter int STUCK_CYCLES    = 200,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor_raw,
    input  logic       own_green,
    output logic       cars,
    output logic       det,
    output logic       fault,
    output logic [1:0] state
);

    // Elaboration-time sanity checks on the configuration.
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || STUCK_CYCLES < 1) begin : g_bad_cycles
        $error("DEBOUNCE_CYCLES, HOLD_CYCLES and STUCK_CYCLES must be at least 1");
    end
    if (DEBOUNCE_CYCLES >= (1 << CNT_W) || HOLD_CYCLES >= (1 << CNT_W) ||
        STUCK_CYCLES >= (1 << CNT_W)) begin : g_bad_width
        $error("CNT_W too narrow for the configured cycle counts");
    end

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SERVING = 2'd2
    } req_state_t;

    // ------------------------------------------------------------------
    // Synchroniser: shift chain, oldest sample at the top bit.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_lvl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sensor_raw};
        end
    end

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debouncer. The counter tracks consecutive cycles where the
    // synchronised level disagrees with the debounced level. Any agreeing
    // cycle clears it, so only a run of DEBOUNCE_CYCLES disagreeing cycles
    // flips det. The toggle happens on the edge where the count would
    // reach DEBOUNCE_CYCLES, which is why we compare against N-1.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] db_cnt_q;
    logic             det_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt_q <= '0;
            det_q    <= 1'b0;
        end else if (sync_lvl != det_q) begin
            if (db_cnt_q == DB_LAST) begin
                det_q    <= ~det_q;
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end else begin
            db_cnt_q <= '0;
        end
    end

    assign det = det_q;

    // ------------------------------------------------------------------
    // Request FSM. cars_q is assigned together with every state change,
    // so it is the registered decode of the next state and moves on the
    // same edge as the state.
    //
    // PENDING ignores det. Once seen, a vehicle's demand stays latched
    // until green is given, even if the sensor drops out.
    // In SERVING, the hold counter stretches the request after the
    // vehicle leaves, so a queue that briefly gaps is not cut off.
    // ------------------------------------------------------------------
    req_state_t       state_q;
    logic             cars_q;
    logic [CNT_W-1:0] hold_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cars_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (det_q) begin
                        state_q <= PENDING;
                        cars_q  <= 1'b1;
                    end
                end

                PENDING: begin
                    cars_q <= 1'b1;
                    if (own_green) begin
                        state_q <= SERVING;
                        hold_q  <= HOLD_LOAD;
                    end
                end

                SERVING: begin
                    // Presence reloads the stretch; absence drains it,
                    // saturating at zero.
                    if (det_q) begin
                        hold_q <= HOLD_LOAD;
                    end else if (hold_q != '0) begin
                        hold_q <= hold_q - 1'b1;
                    end

                    if (!own_green) begin
                        // Green taken away: keep asking if someone is
                        // still waiting, otherwise drop the request.
                        if (det_q) begin
                            state_q <= PENDING;
                            cars_q  <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            cars_q  <= 1'b0;
                        end
                    end else if (!det_q && hold_q == '0) begin
                        state_q <= IDLE;
                        cars_q  <= 1'b0;
                    end else begin
                        cars_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    cars_q  <= 1'b0;
                end
            endcase
        end
    end

    assign state = state_q;

`ifdef STUCK_DETECT_EN
    // ------------------------------------------------------------------
    // Stuck-sensor detector. It counts consecutive debounced-present
    // cycles, saturating at STUCK_CYCLES. The fault is set on the edge
    // where the count reaches STUCK_CYCLES and stays set until reset.
    // While faulted, the request is forced high. The FSM keeps running
    // underneath so that it is in a consistent state.
    // ------------------------------------------------------------------
    localparam logic [CNT_W-1:0] STUCK_LIM  = CNT_W'(STUCK_CYCLES);
    localparam logic [CNT_W-1:0] STUCK_LAST = CNT_W'(STUCK_CYCLES - 1);

    logic [CNT_W-1:0] stuck_q;
    logic             fault_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stuck_q <= '0;
            fault_q <= 1'b0;
        end else begin
            if (!det_q) begin
                stuck_q <= '0;
            end else if (stuck_q != STUCK_LIM) begin
                stuck_q <= stuck_q + 1'b1;
            end

            if (det_q && stuck_q == STUCK_LAST) begin
                fault_q <= 1'b1;
            end
        end
    end

    assign fault = fault_q;
    assign cars  = cars_q | fault_q;
`else
    assign fault = 1'b0;
    assign cars  = cars_q;
`endif

endmodule

// ---------------------------------------------------------------------------
// Top level: two identical, independent channels.
// ---------------------------------------------------------------------------
module traffic_request_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 16,
    parameter int STUCK_CYCLES    = 200,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor_ns_raw,
    input  logic       sensor_ew_raw,
    input  logic       green_N,
    input  logic       green_E,
    output logic       cars_ns,
    output logic       cars_ew,
    output logic       det_ns,
    output logic       det_ew,
    output logic       fault_ns,
    output logic       fault_ew,
    output logic [1:0] state_ns,
    output logic [1:0] state_ew
);

    traffic_request_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES),
        .CNT_W           (CNT_W)
    ) u_ns (
        .clk        (clk),
        .rst        (rst),
        .sensor_raw (sensor_ns_raw),
        .own_green  (green_N),
        .cars       (cars_ns),
        .det        (det_ns),
        .fault      (fault_ns),
        .state      (state_ns)
    );

    traffic_request_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES),
        .CNT_W           (CNT_W)
    ) u_ew (
        .clk        (clk),
        .rst        (rst),
        .sensor_raw (sensor_ew_raw),
        .own_green  (green_E),
        .cars       (cars_ew),
        .det        (det_ew),
        .fault      (fault_ew),
        .state      (state_ew)
    );

endmodule
